i_mem_responder: RTL and testbench



---
 rtl/i_mem_responder.sv | 144 ++++++++++++++
 tb/tb_i_mem_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_responder.sv
// Instruction-memory bus target: queues fetch addresses and returns one word per request
// after a configurable number of wait states. Contents are preloaded through the load port.
module i_mem_responder #(
    parameter int unsigned data_width  = 32,
    parameter int unsigned addr_width  = 32,
    parameter int unsigned mem_depth   = 256,
    parameter int unsigned wait_cycles = 0,
    parameter int unsigned req_depth   = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         bus_ir_addr_valid,
    output logic                         bus_ir_addr_ready,
    input  logic [addr_width-1:0]        bus_ir_addr,
    output logic                         bus_ir_data_valid,
    input  logic                         bus_ir_data_ready,
    output logic [data_width-1:0]        bus_ir_data,
    input  logic                         load_en,
    input  logic [$clog2(mem_depth)-1:0] load_addr,
    input  logic [data_width-1:0]        load_data
);

    localparam int unsigned IdxW = $clog2(mem_depth);
    localparam int unsigned PtrW = $clog2(req_depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [7:0]  WaitInit = 8'(wait_cycles);
    localparam bit          NoWait   = (wait_cycles == 0);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StRead = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [data_width-1:0] mem [mem_depth];
    logic [IdxW-1:0]       queue_q [req_depth];

    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  rdy_q;
    logic [1:0]            state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  push, pop;
    logic                  unused_addr;

    // Upper address bits alias onto the same words.
    assign unused_addr = ^bus_ir_addr;
    assign push        = bus_ir_addr_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            StWait: begin
                if (wait_q == 8'd1) begin
                    state_d = StRead;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            StRead: begin
                data_d  = mem[idx_q];
                valid_d = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (bus_ir_data_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A dequeue from idle or on a response handshake starts the next access directly.
        if (pop) begin
            idx_d = queue_q[rd_ptr_q];
            if (NoWait) begin
                state_d = StRead;
            end else begin
                state_d = StWait;
                wait_d  = WaitInit;
            end
        end

        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
            wait_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_q + PtrW'(push);
            rd_ptr_q <= rd_ptr_q + PtrW'(pop);
            rdy_q    <= (count_d != CntW'(req_depth));
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            queue_q[wr_ptr_q] <= bus_ir_addr[IdxW-1:0];
        end
    end

    // Memory is never reset; loads are only honoured outside reset.
    always_ff @(posedge clock) begin
        if (load_en && reset_n) begin
            mem[load_addr] <= load_data;
        end
    end

    assign bus_ir_addr_ready = rdy_q;
    assign bus_ir_data_valid = valid_q;
    assign bus_ir_data       = data_q;

endmodule

// File: tb/tb_i_mem_responder.sv
// Bench for i_mem_responder: directed latency/ordering/reset scenarios on a zero-wait and a
// three-wait instance, then randomized traffic against a scoreboard of expected words.
module tb_i_mem_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic        av_a, ar_a, dv_a, dr_a;
    logic [31:0] addr_a, d_a;
    logic        av_b, ar_b, dv_b, dr_b;
    logic [31:0] addr_b, d_b;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] mem_m [256];

    always #5 clock = ~clock;

    i_mem_responder #(
        .data_width(32), .addr_width(32), .mem_depth(256), .wait_cycles(0), .req_depth(2)
    ) dut_a (
        .clock(clock), .reset_n(reset_n),
        .bus_ir_addr_valid(av_a), .bus_ir_addr_ready(ar_a), .bus_ir_addr(addr_a),
        .bus_ir_data_valid(dv_a), .bus_ir_data_ready(dr_a), .bus_ir_data(d_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    i_mem_responder #(
        .data_width(32), .addr_width(32), .mem_depth(256), .wait_cycles(3), .req_depth(2)
    ) dut_b (
        .clock(clock), .reset_n(reset_n),
        .bus_ir_addr_valid(av_b), .bus_ir_addr_ready(ar_b), .bus_ir_addr(addr_b),
        .bus_ir_data_valid(dv_b), .bus_ir_data_ready(dr_b), .bus_ir_data(d_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    // All tasks begin and end on a falling edge.
    task automatic do_load(input logic [7:0] i, input logic [31:0] d);
        load_en = 1'b1; load_addr = i; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
        if (reset_n) mem_m[i] = d;
    endtask

    task automatic get_resp_a(input logic [31:0] a, output logic [31:0] d, output bit ok);
        int n;
        dr_a = 1'b1; av_a = 1'b1; addr_a = a; n = 0;
        while (!ar_a && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        av_a = 1'b0; n = 0;
        while (!dv_a && n < 20) begin @(negedge clock); n++; end
        ok = dv_a; d = d_a;
        @(negedge clock);
    endtask

    task automatic get_resp_b(input logic [31:0] a, output logic [31:0] d, output bit ok);
        int n;
        dr_b = 1'b1; av_b = 1'b1; addr_b = a; n = 0;
        while (!ar_b && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        av_b = 1'b0; n = 0;
        while (!dv_b && n < 30) begin @(negedge clock); n++; end
        ok = dv_b; d = d_b;
        @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({dv_a, ar_a, dv_b, ar_b} !== 4'b0000)
            $display("FAIL reset_flags got %b exp 0000", {dv_a, ar_a, dv_b, ar_b});
        else passed++;
        checks++;
        if (d_a !== 32'h0 || d_b !== 32'h0)
            $display("FAIL reset_data got %h/%h exp 0", d_a, d_b);
        else passed++;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (ar_a !== 1'b1 || ar_b !== 1'b1)
            $display("FAIL ready_after_reset got %b%b exp 11", ar_a, ar_b);
        else passed++;
    endtask

    task automatic test_single;
        do_load(8'd5, 32'hDEADBEEF);
        checks++;
        if (ar_a !== 1'b1) $display("FAIL single_ready0 got %b exp 1", ar_a);
        else passed++;
        dr_a = 1'b1; av_a = 1'b1; addr_a = 32'd5;
        @(negedge clock);
        av_a = 1'b0;
        // k counts edges after the accepting edge E0, sampled after E0+k.
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dv_a !== (k == 2))
                $display("FAIL single_valid k=%0d got %b exp %b", k, dv_a, (k == 2));
            else passed++;
            if (k == 2) begin
                checks++;
                if (d_a !== 32'hDEADBEEF)
                    $display("FAIL single_data got %h exp deadbeef", d_a);
                else passed++;
            end
            checks++;
            if (ar_a !== 1'b1) $display("FAIL single_ready k=%0d got %b exp 1", k, ar_a);
            else passed++;
            @(negedge clock);
        end
    endtask

    task automatic test_wait3;
        int sent, rcv, first_v;
        int acc_t [3];
        int resp_t [3];
        logic [31:0] resp_d [3];
        do_load(8'd1, 32'd1);
        do_load(8'd2, 32'd2);
        do_load(8'd3, 32'd3);
        sent = 0; rcv = 0; first_v = -1;
        dr_b = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (sent == 3 && t == acc_t[2] + 1) begin
                checks++;
                if (ar_b !== 1'b0) $display("FAIL wait3_full_ready got %b exp 0", ar_b);
                else passed++;
            end
            if (dv_b && first_v < 0) first_v = t;
            if (sent < 3) begin av_b = 1'b1; addr_b = 32'(sent + 1); end
            else av_b = 1'b0;
            if (av_b && ar_b) begin acc_t[sent] = t; sent++; end
            if (dv_b && dr_b && rcv < 3) begin
                resp_t[rcv] = t; resp_d[rcv] = d_b; rcv++;
            end
            @(negedge clock);
        end
        av_b = 1'b0;
        checks++;
        if (rcv !== 3) $display("FAIL wait3_count got %0d exp 3", rcv);
        else passed++;
        if (rcv == 3) begin
            checks++;
            if (first_v !== acc_t[0] + 6)
                $display("FAIL wait3_latency got %0d exp %0d", first_v - acc_t[0], 6);
            else passed++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (resp_d[i] !== 32'(i + 1))
                    $display("FAIL wait3_order i=%0d got %h exp %h", i, resp_d[i], i + 1);
                else passed++;
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (resp_t[i+1] - resp_t[i] - 1 !== 4)
                    $display("FAIL wait3_gap i=%0d got %0d exp 4", i,
                             resp_t[i+1] - resp_t[i] - 1);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] v, held;
        int n;
        v = $urandom();
        do_load(8'd9, v);
        dr_a = 1'b0; av_a = 1'b1; addr_a = 32'd9;
        @(negedge clock);
        av_a = 1'b0; n = 0;
        while (!dv_a && n < 10) begin @(negedge clock); n++; end
        held = d_a;
        checks++;
        if (dv_a !== 1'b1 || held !== v)
            $display("FAIL bp_first got %b/%h exp 1/%h", dv_a, held, v);
        else passed++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checks++;
            if (dv_a !== 1'b1 || d_a !== held)
                $display("FAIL bp_hold k=%0d got %b/%h exp 1/%h", k, dv_a, d_a, held);
            else passed++;
        end
        dr_a = 1'b1;
        @(negedge clock);
        checks++;
        if (dv_a !== 1'b0) $display("FAIL bp_consume got %b exp 0", dv_a);
        else passed++;
    endtask

    task automatic test_alias;
        logic [31:0] d;
        bit ok;
        do_load(8'h10, 32'h12345678);
        get_resp_a(32'h0000_0110, d, ok);
        checks++;
        if (!ok || d !== 32'h12345678)
            $display("FAIL alias_data got %b/%h exp 1/12345678", ok, d);
        else passed++;
    endtask

    task automatic test_collision;
        logic [31:0] a_w, b_w, d;
        bit ok;
        a_w = $urandom(); b_w = ~a_w;
        do_load(8'd7, a_w);
        dr_a = 1'b1; av_a = 1'b1; addr_a = 32'd7;
        @(negedge clock);
        av_a = 1'b0;
        @(negedge clock);
        do_load(8'd7, b_w); // lands on the READ edge
        checks++;
        if (dv_a !== 1'b1 || d_a !== a_w)
            $display("FAIL collide_old got %b/%h exp 1/%h", dv_a, d_a, a_w);
        else passed++;
        @(negedge clock);
        get_resp_a(32'd7, d, ok);
        checks++;
        if (!ok || d !== b_w) $display("FAIL collide_new got %b/%h exp 1/%h", ok, d, b_w);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bit ok;
        int n, bad;
        dr_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            av_b = 1'b1; addr_b = 32'(i + 1); n = 0;
            while (!ar_b && n < 20) begin @(negedge clock); n++; end
            @(negedge clock);
        end
        av_b = 1'b0; n = 0;
        while (!dv_b && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        checks++;
        if (dv_b !== 1'b1) $display("FAIL rmid_inresp got %b exp 1", dv_b);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dv_b !== 1'b0 || ar_b !== 1'b0 || d_b !== 32'h0)
            $display("FAIL rmid_async got %b%b/%h exp 00/0", dv_b, ar_b, d_b);
        else passed++;
        @(negedge clock);
        load_en = 1'b1; load_addr = 8'd1; load_data = 32'hFFFF_FFFF;
        @(negedge clock);
        load_en = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (ar_b !== 1'b1) $display("FAIL rmid_ready got %b exp 1", ar_b);
        else passed++;
        dr_b = 1'b1; bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (dv_b) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad !== 0) $display("FAIL rmid_stale got %0d valid cycles exp 0", bad);
        else passed++;
        get_resp_b(32'd1, d, ok);
        checks++;
        if (!ok || d !== mem_m[1]) $display("FAIL rmid_mem got %b/%h exp 1/%h", ok, d, mem_m[1]);
        else passed++;
    endtask

    task automatic test_random;
        logic [31:0] sb [$];
        logic [7:0]  qi [$];
        int          pend [256];
        logic [31:0] r, hold_data, exp_w;
        logic [7:0]  aidx, li;
        bit          acc, hold_prev;
        int          n;
        for (int i = 0; i < 256; i++) pend[i] = 0;
        for (int i = 0; i < 16; i++) do_load(8'(i), $urandom());
        hold_prev = 1'b0; hold_data = '0;
        for (int t = 0; t < 600; t++) begin
            if (hold_prev) begin
                checks++;
                if (dv_b !== 1'b1 || d_b !== hold_data)
                    $display("FAIL rnd_hold t=%0d got %b/%h exp 1/%h", t, dv_b, d_b, hold_data);
                else passed++;
            end
            r = $urandom();
            av_b = ($urandom_range(0, 1) == 1);
            addr_b = (r & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            dr_b = ($urandom_range(0, 3) != 0);
            aidx = addr_b[7:0];
            acc = av_b && ar_b;
            if (acc) begin
                sb.push_back(mem_m[aidx]); qi.push_back(aidx); pend[aidx]++;
            end
            load_en = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                li = 8'($urandom_range(0, 15));
                if (pend[li] == 0 && !(acc && li == aidx)) begin
                    load_en = 1'b1; load_addr = li; load_data = $urandom();
                    mem_m[li] = load_data;
                end
            end
            if (dv_b && dr_b) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rnd_extra t=%0d got %h exp none", t, d_b);
                end else begin
                    exp_w = sb.pop_front();
                    pend[qi.pop_front()]--;
                    if (d_b !== exp_w) $display("FAIL rnd_data t=%0d got %h exp %h", t, d_b, exp_w);
                    else passed++;
                end
            end
            hold_prev = dv_b && !dr_b;
            hold_data = d_b;
            @(negedge clock);
        end
        load_en = 1'b0; av_b = 1'b0; dr_b = 1'b1; n = 0;
        while (n < 60) begin
            if (dv_b) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rnd_drain_extra got %h exp none", d_b);
                end else begin
                    exp_w = sb.pop_front();
                    void'(qi.pop_front());
                    if (d_b !== exp_w) $display("FAIL rnd_drain got %h exp %h", d_b, exp_w);
                    else passed++;
                end
            end
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) $display("FAIL rnd_missing got %0d left exp 0", sb.size());
        else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        av_a = 1'b0; addr_a = '0; dr_a = 1'b0;
        av_b = 1'b0; addr_b = '0; dr_b = 1'b0;
        test_reset;
        test_single;
        test_wait3;
        test_backpressure;
        test_alias;
        test_collision;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
